// File: rtl/ps2_packet_decoder.sv
// Assembles 3-byte PS/2 mouse packets into button states and a clamped cell-grid cursor position.
// Latency: 2 cycles from the byte2 strobe. No backpressure; optional macro PS2_MOUSE_ACCEL_EN doubles large deltas.
module ps2_packet_decoder #(
    parameter int SCREEN_WIDTH      = 160,
    parameter int SCREEN_HEIGHT     = 120,
    parameter int CELL_WIDTH        = 5,
    parameter int SENSITIVITY_SHIFT = 2,
    parameter int TIMEOUT_CYCLES    = 50000
) (
    input  logic       iClk,
    input  logic       iResetn,
    input  logic [7:0] iByte,
    input  logic       iByteValid,
    output logic       oBtnL,
    output logic       oBtnR,
    output logic       oBtnM,
    output logic [7:0] oX_cell,
    output logic [7:0] oY_cell,
    output logic       oPacketValid,
    output logic       oSyncError
);

    localparam int MAX_X_CELL = SCREEN_WIDTH / CELL_WIDTH - 1;
    localparam int MAX_Y_CELL = SCREEN_HEIGHT / CELL_WIDTH - 1;
    localparam int SH         = SENSITIVITY_SHIFT;
    localparam int TW         = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic signed [9:0] MAX_X10 = 10'(MAX_X_CELL);
    localparam logic signed [9:0] MAX_Y10 = 10'(MAX_Y_CELL);
    localparam logic [TW-1:0]     T_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2, APPLY} state_t;

    state_t        state;
    logic [7:0]    byte0, byte1, byte2;
    logic [SH-1:0] acc_x, acc_y;
    logic [TW-1:0] tcnt;

    function automatic logic signed [11:0] axis_delta(input logic sign, input logic [7:0] low,
                                                      input logic ovf);
        logic signed [11:0] d;
        d = ovf ? 12'sd0 : $signed({{4{sign}}, low});
`ifdef PS2_MOUSE_ACCEL_EN
        if (d >= 12'sd32 || d <= -12'sd32)
            d = d <<< 1;
`endif
        return d;
    endfunction

    logic signed [11:0] dx, dy, sum_x, sum_y, step_x, step_y;
    logic signed [9:0]  pos_x, pos_y;
    logic [7:0]         new_x, new_y;
    logic [SH-1:0]      new_acc_x, new_acc_y;

    // Remainder kept as the low bits of the sum, so it is always non-negative.
    always_comb begin
        dx        = axis_delta(byte0[4], byte1, byte0[6]);
        dy        = axis_delta(byte0[5], byte2, byte0[7]);
        sum_x     = $signed({{(12-SH){1'b0}}, acc_x}) + dx;
        sum_y     = $signed({{(12-SH){1'b0}}, acc_y}) + dy;
        step_x    = sum_x >>> SH;
        step_y    = sum_y >>> SH;
        pos_x     = $signed({2'b00, oX_cell}) + step_x[9:0];
        pos_y     = $signed({2'b00, oY_cell}) - step_y[9:0];
        new_acc_x = sum_x[SH-1:0];
        new_acc_y = sum_y[SH-1:0];
        new_x     = pos_x[7:0];
        new_y     = pos_y[7:0];
        if (pos_x < 10'sd0) begin
            new_x     = 8'd0;
            new_acc_x = '0;
        end else if (pos_x > MAX_X10) begin
            new_x     = MAX_X10[7:0];
            new_acc_x = '0;
        end
        if (pos_y < 10'sd0) begin
            new_y     = 8'd0;
            new_acc_y = '0;
        end else if (pos_y > MAX_Y10) begin
            new_y     = MAX_Y10[7:0];
            new_acc_y = '0;
        end
    end

    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            state        <= WAIT_B0;
            byte0        <= 8'd0;
            byte1        <= 8'd0;
            byte2        <= 8'd0;
            acc_x        <= '0;
            acc_y        <= '0;
            tcnt         <= '0;
            oBtnL        <= 1'b0;
            oBtnR        <= 1'b0;
            oBtnM        <= 1'b0;
            oX_cell      <= 8'(MAX_X_CELL / 2);
            oY_cell      <= 8'(MAX_Y_CELL / 2);
            oPacketValid <= 1'b0;
            oSyncError   <= 1'b0;
        end else begin
            oPacketValid <= 1'b0;
            oSyncError   <= 1'b0;
            case (state)
                WAIT_B0, APPLY: begin
                    if (state == APPLY) begin
                        oBtnL        <= byte0[0];
                        oBtnR        <= byte0[1];
                        oBtnM        <= byte0[2];
                        oX_cell      <= new_x;
                        oY_cell      <= new_y;
                        acc_x        <= new_acc_x;
                        acc_y        <= new_acc_y;
                        oPacketValid <= 1'b1;
                    end
                    // A byte arriving during APPLY is treated as a fresh byte0.
                    tcnt  <= '0;
                    state <= WAIT_B0;
                    if (iByteValid) begin
                        if (iByte[3]) begin
                            byte0 <= iByte;
                            state <= WAIT_B1;
                        end else begin
                            oSyncError <= 1'b1;
                        end
                    end
                end
                WAIT_B1, WAIT_B2: begin
                    if (iByteValid) begin
                        tcnt <= '0;
                        if (state == WAIT_B1) begin
                            byte1 <= iByte;
                            state <= WAIT_B2;
                        end else begin
                            byte2 <= iByte;
                            state <= APPLY;
                        end
                    end else if (tcnt == T_LAST) begin
                        tcnt  <= '0;
                        state <= WAIT_B0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= WAIT_B0;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_packet_decoder.sv
// Randomized and directed bench for ps2_packet_decoder against a packet-level reference model.
module tb_ps2_packet_decoder;

    logic       iClk = 1'b0;
    logic       iResetn = 1'b0;
    logic [7:0] iByte = 8'd0;
    logic       iByteValid = 1'b0;
    logic       oBtnL, oBtnR, oBtnM, oPacketValid, oSyncError;
    logic [7:0] oX_cell, oY_cell;

    ps2_packet_decoder dut (
        .iClk(iClk), .iResetn(iResetn), .iByte(iByte), .iByteValid(iByteValid),
        .oBtnL(oBtnL), .oBtnR(oBtnR), .oBtnM(oBtnM),
        .oX_cell(oX_cell), .oY_cell(oY_cell),
        .oPacketValid(oPacketValid), .oSyncError(oSyncError)
    );

    always #5 iClk = ~iClk;

    int vectors = 0;
    int miscompares = 0;

    int   m_x, m_y, m_ax, m_ay;
    logic m_l, m_r, m_m;

    task automatic model_reset();
        m_x = 15; m_y = 11; m_ax = 0; m_ay = 0;
        m_l = 1'b0; m_r = 1'b0; m_m = 1'b0;
    endtask

    // 4 counts per cell: floor-divide the running sum, keep a non-negative remainder.
    task automatic model_axis(inout int acc, inout int pos, input int delta, input int dir,
                              input int maxv);
        int sum, rem, step, np;
`ifdef PS2_MOUSE_ACCEL_EN
        if (delta >= 32 || delta <= -32) delta = delta * 2;
`endif
        sum  = acc + delta;
        rem  = ((sum % 4) + 4) % 4;
        step = (sum - rem) / 4;
        np   = pos + dir * step;
        if (np < 0) begin np = 0; rem = 0; end
        else if (np > maxv) begin np = maxv; rem = 0; end
        pos = np;
        acc = rem;
    endtask

    task automatic model_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        int dx, dy;
        dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
        dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
        model_axis(m_ax, m_x, dx, 1, 31);
        model_axis(m_ay, m_y, dy, -1, 23);
        m_l = b0[0]; m_r = b0[1]; m_m = b0[2];
    endtask

    function automatic logic [18:0] model_vec();
        return {m_l, m_r, m_m, m_x[7:0], m_y[7:0]};
    endfunction

    function automatic logic [18:0] dut_vec();
        return {oBtnL, oBtnR, oBtnM, oX_cell, oY_cell};
    endfunction

    task automatic do_reset();
        iResetn = 1'b0;
        iByteValid = 1'b0;
        model_reset();
        repeat (2) @(negedge iClk);
        iResetn = 1'b1;
        @(negedge iClk);
    endtask

    // Called at a negedge; returns at the next negedge with the strobe dropped.
    task automatic send_byte(input logic [7:0] b);
        iByte = b;
        iByteValid = 1'b1;
        @(negedge iClk);
        iByteValid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int gap);
        logic [18:0] old_v, new_v;
        old_v = model_vec();
        model_packet(b0, b1, b2);
        new_v = model_vec();
        send_byte(b0);
        repeat (gap) @(negedge iClk);
        send_byte(b1);
        repeat (gap) @(negedge iClk);
        send_byte(b2);
        vectors++;
        if (oPacketValid !== 1'b0 || dut_vec() !== old_v) begin
            miscompares++;
            $display("FAIL pkt_early: pv=%b out=%h required pv=0 out=%h", oPacketValid, dut_vec(), old_v);
        end
        @(negedge iClk);
        vectors++;
        if (oPacketValid !== 1'b1 || dut_vec() !== new_v) begin
            miscompares++;
            $display("FAIL pkt_apply: pv=%b out=%h required pv=1 out=%h", oPacketValid, dut_vec(), new_v);
        end
        @(negedge iClk);
        vectors++;
        if (oPacketValid !== 1'b0 || dut_vec() !== new_v) begin
            miscompares++;
            $display("FAIL pkt_hold: pv=%b out=%h required pv=0 out=%h", oPacketValid, dut_vec(), new_v);
        end
    endtask

    task automatic check_x(input string name, input logic [7:0] exp);
        vectors++;
        if (oX_cell !== exp) begin
            miscompares++;
            $display("FAIL %s: x=%0d required %0d", name, oX_cell, exp);
        end
    endtask

    task automatic check_y(input string name, input logic [7:0] exp);
        vectors++;
        if (oY_cell !== exp) begin
            miscompares++;
            $display("FAIL %s: y=%0d required %0d", name, oY_cell, exp);
        end
    endtask

    task automatic test_reset();
        logic bad;
        do_reset();
        vectors++;
        if (dut_vec() !== {3'b000, 8'd15, 8'd11} || oPacketValid !== 1'b0 || oSyncError !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: out=%h pv=%b se=%b required out=%h pulses 0",
                     dut_vec(), oPacketValid, oSyncError, {3'b000, 8'd15, 8'd11});
        end
        bad = 1'b0;
        repeat (100) begin
            @(negedge iClk);
            if (dut_vec() !== {3'b000, 8'd15, 8'd11} || oPacketValid || oSyncError) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL reset_idle: outputs moved=%b required 0", bad);
        end
    endtask

    task automatic test_basic();
        do_reset();
        send_pkt(8'h09, 8'h08, 8'h00, 0);
        check_x("basic_x", 8'd17);
        check_y("basic_y", 8'd11);
        vectors++;
        if (oBtnL !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_btnl: L=%b required 1", oBtnL);
        end
    endtask

    task automatic test_accumulate();
        do_reset();
        send_pkt(8'h08, 8'h03, 8'h00, 1);
        check_x("acc_first", 8'd15);
        send_pkt(8'h08, 8'h03, 8'h00, 1);
        check_x("acc_second", 8'd16);
        send_pkt(8'h18, 8'hF8, 8'h00, 2);
        check_x("acc_negative", 8'd14);
    endtask

    task automatic test_clamp();
        do_reset();
        send_pkt(8'h08, 8'h00, 8'h28, 0);
        check_y("clamp_y1", 8'd1);
        send_pkt(8'h08, 8'h00, 8'h28, 0);
        check_y("clamp_y0", 8'd0);
        send_pkt(8'h48, 8'hFF, 8'h00, 0);
        check_x("overflow_x", 8'd15);
        // Remainder of 2 before the clamp: a -2 move only lands on row 1 if it was cleared.
        do_reset();
        send_pkt(8'h08, 8'h00, 8'h29, 0);
        send_pkt(8'h08, 8'h00, 8'h29, 0);
        check_y("clamp_pre", 8'd0);
        send_pkt(8'h28, 8'h00, 8'hFE, 0);
        check_y("clamp_acc_cleared", 8'd1);
        do_reset();
        send_pkt(8'h18, 8'h80, 8'h00, 0);
        check_x("clamp_x0", 8'd0);
    endtask

    task automatic test_sync_timeout();
        logic bad;
        do_reset();
        send_byte(8'h00);
        vectors++;
        if (oSyncError !== 1'b1 || oPacketValid !== 1'b0) begin
            miscompares++;
            $display("FAIL sync_pulse: se=%b pv=%b required se=1 pv=0", oSyncError, oPacketValid);
        end
        @(negedge iClk);
        vectors++;
        if (oSyncError !== 1'b0 || dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL sync_after: se=%b out=%h required se=0 out=%h", oSyncError, dut_vec(), model_vec());
        end
        send_byte(8'h08);
        send_byte(8'h10);
        bad = 1'b0;
        repeat (50010) begin
            @(negedge iClk);
            if (oPacketValid || oSyncError || dut_vec() !== model_vec()) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL timeout_idle: change seen=%b required 0", bad);
        end
        send_pkt(8'h08, 8'h04, 8'h00, 0);
        check_x("timeout_resync", 8'd16);
        do_reset();
        send_pkt(8'h08, 8'h10, 8'h00, 1000);
        check_x("slow_packet", 8'd19);
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_pkt(8'h09, 8'h08, 8'h00, 0);
        send_byte(8'h08);
        send_byte(8'h10);
        #2 iResetn = 1'b0;
        #1;
        vectors++;
        if (dut_vec() !== {3'b000, 8'd15, 8'd11}) begin
            miscompares++;
            $display("FAIL async_reset: out=%h required %h", dut_vec(), {3'b000, 8'd15, 8'd11});
        end
        model_reset();
        @(negedge iClk);
        iResetn = 1'b1;
        @(negedge iClk);
        send_pkt(8'h08, 8'h04, 8'h00, 0);
        check_x("reset_discard", 8'd16);
    endtask

    task automatic test_accel();
        do_reset();
        send_pkt(8'h08, 8'h28, 8'h00, 0);
`ifdef PS2_MOUSE_ACCEL_EN
        check_x("accel_x", 8'd31);
`else
        check_x("accel_x", 8'd25);
`endif
    endtask

    task automatic test_back_to_back();
        logic [18:0] v1, v2;
        do_reset();
        model_packet(8'h09, 8'h08, 8'h00);
        v1 = model_vec();
        model_packet(8'h1A, 8'hF0, 8'h00);
        v2 = model_vec();
        send_byte(8'h09);
        send_byte(8'h08);
        send_byte(8'h00);
        send_byte(8'h1A);
        vectors++;
        if (oPacketValid !== 1'b1 || dut_vec() !== v1) begin
            miscompares++;
            $display("FAIL b2b_first: pv=%b out=%h required pv=1 out=%h", oPacketValid, dut_vec(), v1);
        end
        send_byte(8'hF0);
        send_byte(8'h00);
        @(negedge iClk);
        vectors++;
        if (oPacketValid !== 1'b1 || dut_vec() !== v2) begin
            miscompares++;
            $display("FAIL b2b_second: pv=%b out=%h required pv=1 out=%h", oPacketValid, dut_vec(), v2);
        end
    endtask

    task automatic test_random();
        logic [18:0] exp_q[$];
        logic [18:0] e;
        int   exp_sync, seen_sync;
        logic done;
        logic [7:0] b0, b1, b2, bad;
        do_reset();
        exp_sync = 0;
        seen_sync = 0;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(7) == 0) begin
                        bad = 8'($urandom) & 8'hF7;
                        send_byte(bad);
                        exp_sync++;
                        repeat ($urandom_range(2)) @(negedge iClk);
                    end
                    b0 = (8'($urandom) & 8'h3F) | 8'h08;
                    if ($urandom_range(7) == 0) b0[6] = 1'b1;
                    if ($urandom_range(7) == 0) b0[7] = 1'b1;
                    b1 = 8'($urandom);
                    b2 = 8'($urandom);
                    model_packet(b0, b1, b2);
                    exp_q.push_back(model_vec());
                    send_byte(b0);
                    repeat ($urandom_range(2)) @(negedge iClk);
                    send_byte(b1);
                    repeat ($urandom_range(2)) @(negedge iClk);
                    send_byte(b2);
                    repeat ($urandom_range(3)) @(negedge iClk);
                end
                repeat (6) @(negedge iClk);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge iClk);
                    if (oSyncError === 1'b1) seen_sync++;
                    if (oPacketValid === 1'b1) begin
                        vectors++;
                        if (exp_q.size() == 0) begin
                            miscompares++;
                            $display("FAIL rand_extra_pkt: out=%h required no packet", dut_vec());
                        end else begin
                            e = exp_q.pop_front();
                            if (dut_vec() !== e) begin
                                miscompares++;
                                $display("FAIL rand_pkt: out=%h required %h", dut_vec(), e);
                            end
                        end
                    end
                end
            end
        join
        vectors++;
        if (seen_sync != exp_sync || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rand_counts: sync=%0d pending=%0d required sync=%0d pending=0",
                     seen_sync, exp_q.size(), exp_sync);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_accumulate();
        test_clamp();
        test_sync_timeout();
        test_reset_mid();
        test_accel();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
